// File: rtl/updown_ctrl.sv
// Run/pause/direction/clear controller driving the enable, direction and clear of a 4-bit up/down counter.
// Optional limit bounce (reverse at all-ones / zero) is built when UPDOWN_BOUNCE_MODE_EN is defined.
module updown_ctrl #(
    parameter int unsigned TICK_DIV  = 67108864,
    parameter int unsigned DB_CYCLES = 1000000,
    parameter int unsigned CNT_W     = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             btn_run,
    input  logic             btn_dir,
    input  logic             btn_clr,
    input  logic [CNT_W-1:0] cnt_value,
    output logic             cnt_tick,
    output logic             cnt_up,
    output logic             cnt_clr,
    output logic [1:0]       state,
    output logic             run_led
);

    localparam int unsigned PW = $clog2(TICK_DIV);
    localparam int unsigned DW = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
    localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);
    localparam logic [DW-1:0] DB_LAST    = DW'(DB_CYCLES - 1);
    localparam int unsigned B_RUN = 0;
    localparam int unsigned B_DIR = 1;
    localparam int unsigned B_CLR = 2;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_RUN   = 2'b01,
        ST_PAUSE = 2'b10,
        ST_CLEAR = 2'b11
    } state_t;

    logic [2:0]    btn_raw_s;
    logic [2:0]    sync1_q;
    logic [2:0]    sync2_q;
    logic [2:0]    deb_q;
    logic [2:0]    deb_d;
    logic [2:0]    press_q;
    logic [2:0]    press_d;
    logic [DW-1:0] db_cnt_q [3];
    logic [DW-1:0] db_cnt_d [3];

    state_t        state_q;
    state_t        state_d;
    logic [PW-1:0] presc_q;
    logic [PW-1:0] presc_d;
    logic          tick_q;
    logic          tick_d;
    logic          up_q;
    logic          up_d;
    logic          clr_q;
    logic          clr_d;
    logic          led_q;
    logic          led_d;

    assign btn_raw_s = {btn_clr, btn_dir, btn_run};

    // Synchronisers, debounce counters, debounced levels and press pulses for all three buttons
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1_q <= 3'b000;
            sync2_q <= 3'b000;
            deb_q   <= 3'b000;
            press_q <= 3'b000;
            for (int i = 0; i < 3; i++) begin
                db_cnt_q[i] <= {DW{1'b0}};
            end
        end else begin
            sync1_q <= btn_raw_s;
            sync2_q <= sync1_q;
            deb_q   <= deb_d;
            press_q <= press_d;
            for (int i = 0; i < 3; i++) begin
                db_cnt_q[i] <= db_cnt_d[i];
            end
        end
    end

    // A level change is accepted only after DB_CYCLES consecutive disagreeing samples
    always_comb begin
        deb_d   = deb_q;
        press_d = 3'b000;
        for (int i = 0; i < 3; i++) begin
            db_cnt_d[i] = db_cnt_q[i];
            if (sync2_q[i] == deb_q[i]) begin
                db_cnt_d[i] = {DW{1'b0}};
            end else if (db_cnt_q[i] == DB_LAST) begin
                db_cnt_d[i] = {DW{1'b0}};
                deb_d[i]    = sync2_q[i];
                press_d[i]  = sync2_q[i];
            end else begin
                db_cnt_d[i] = db_cnt_q[i] + DW'(1'b1);
            end
        end
    end

    // Sequencer state, prescaler and all registered outputs
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            presc_q <= {PW{1'b0}};
            tick_q  <= 1'b0;
            up_q    <= 1'b1;
            clr_q   <= 1'b0;
            led_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            presc_q <= presc_d;
            tick_q  <= tick_d;
            up_q    <= up_d;
            clr_q   <= clr_d;
            led_q   <= led_d;
        end
    end

    always_comb begin
        state_d = state_q;
        presc_d = presc_q;
        tick_d  = 1'b0;
        up_d    = up_q;

        case (state_q)
            ST_IDLE: begin
                if (press_q[B_RUN]) begin
                    state_d = ST_RUN;
                    presc_d = {PW{1'b0}};
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (press_q[B_RUN]) begin
                    state_d = ST_PAUSE;
                end else begin
                    state_d = ST_RUN;
                end
            end
            ST_PAUSE: begin
                if (press_q[B_RUN]) begin
                    state_d = ST_RUN;
                end else begin
                    state_d = ST_PAUSE;
                end
            end
            ST_CLEAR: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Clear outranks run; a press landing while already in CLEAR is dropped
        if (press_q[B_CLR] && (state_q != ST_CLEAR)) begin
            state_d = ST_CLEAR;
        end else begin
            state_d = state_d;
        end

        if (state_d == ST_CLEAR) begin
            presc_d = {PW{1'b0}};
        end else if ((state_q == ST_RUN) && (state_d == ST_RUN)) begin
            if (presc_q == PRESC_LAST) begin
                presc_d = {PW{1'b0}};
                tick_d  = 1'b1;
            end else begin
                presc_d = presc_q + PW'(1'b1);
            end
        end else begin
            presc_d = presc_d;
        end

        if (press_q[B_DIR] && (state_q != ST_CLEAR)) begin
            up_d = ~up_q;
        end else begin
            up_d = up_q;
        end

`ifdef UPDOWN_BOUNCE_MODE_EN
        // Limits are judged on the value present when the tick is issued
        if (tick_d && up_q && (&cnt_value)) begin
            up_d = 1'b0;
        end else if (tick_d && !up_q && (cnt_value == {CNT_W{1'b0}})) begin
            up_d = 1'b1;
        end else begin
            up_d = up_d;
        end
`endif

        clr_d = (state_d == ST_CLEAR);
        led_d = (state_d == ST_RUN);
    end

`ifndef UPDOWN_BOUNCE_MODE_EN
    logic cnt_value_unused_s;
    assign cnt_value_unused_s = ^cnt_value;
`endif

    assign cnt_tick = tick_q;
    assign cnt_up   = up_q;
    assign cnt_clr  = clr_q;
    assign state    = state_q;
    assign run_led  = led_q;

endmodule

// File: tb/tb_updown_ctrl.sv
// Bench for updown_ctrl: external 4-bit counter, behavioural reference model checked every cycle,
// directed scenarios with literal expectations, then randomized button activity.
module tb_updown_ctrl;

    localparam int TICK_DIV  = 4;
    localparam int DB_CYCLES = 3;
    localparam int CNT_W     = 4;
    localparam int CNT_MOD   = 1 << CNT_W;

    logic             clk     = 1'b0;
    logic             reset   = 1'b0;
    logic             btn_run = 1'b0;
    logic             btn_dir = 1'b0;
    logic             btn_clr = 1'b0;
    logic [CNT_W-1:0] cnt_value;
    logic             cnt_tick;
    logic             cnt_up;
    logic             cnt_clr;
    logic [1:0]       state;
    logic             run_led;

    int n_checks = 0;
    int n_fail   = 0;
    bit check_en = 1'b0;

    updown_ctrl #(
        .TICK_DIV (TICK_DIV),
        .DB_CYCLES(DB_CYCLES),
        .CNT_W    (CNT_W)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .btn_run  (btn_run),
        .btn_dir  (btn_dir),
        .btn_clr  (btn_clr),
        .cnt_value(cnt_value),
        .cnt_tick (cnt_tick),
        .cnt_up   (cnt_up),
        .cnt_clr  (cnt_clr),
        .state    (state),
        .run_led  (run_led)
    );

    always #5 clk = ~clk;

    // The counter datapath this controller drives
    always @(posedge clk or posedge reset) begin
        if (reset)         cnt_value <= '0;
        else if (cnt_clr)  cnt_value <= '0;
        else if (cnt_tick) cnt_value <= cnt_up ? cnt_value + 1'b1 : cnt_value - 1'b1;
    end

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: actual %0d, required %0d at %0t", name, got, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // state codes: 0 idle, 1 run, 2 pause, 3 clear
    int m_state;
    int m_runcnt;      // cycles spent advancing in RUN since the last restart
    bit m_tick;
    bit m_up;
    bit m_clr;
    int m_val;
    bit m_deb   [3];
    bit m_press [3];
    bit hist    [3][DB_CYCLES+2];   // raw samples, index 0 = newest edge

    task automatic m_reset();
        m_state  = 0;
        m_runcnt = 0;
        m_tick   = 1'b0;
        m_up     = 1'b1;
        m_clr    = 1'b0;
        m_val    = 0;
        for (int b = 0; b < 3; b++) begin
            m_deb[b]   = 1'b0;
            m_press[b] = 1'b0;
            for (int j = 0; j < DB_CYCLES + 2; j++) hist[b][j] = 1'b0;
        end
    endtask

    task automatic m_step();
        bit raw [3];
        int nst;
        int nval;
        bit nup;
        bit ntick;
        bit flip;
        raw[0] = btn_run;
        raw[1] = btn_dir;
        raw[2] = btn_clr;

        if (m_state == 3)      nst = 0;
        else if (m_press[2])   nst = 3;
        else if (m_press[0])   nst = (m_state == 1) ? 2 : 1;
        else                   nst = m_state;

        ntick = 1'b0;
        if (m_state == 0 && nst == 1) m_runcnt = 0;
        if (nst == 3) m_runcnt = 0;
        if (m_state == 1 && nst == 1) begin
            m_runcnt++;
            ntick = ((m_runcnt % TICK_DIV) == 0);
        end

        if (m_clr)       nval = 0;
        else if (m_tick) nval = m_up ? (m_val + 1) % CNT_MOD : (m_val + CNT_MOD - 1) % CNT_MOD;
        else             nval = m_val;

        nup = m_up;
        if (m_press[1] && m_state != 3) nup = !m_up;
`ifdef UPDOWN_BOUNCE_MODE_EN
        if (ntick && m_up && m_val == CNT_MOD - 1) nup = 1'b0;
        else if (ntick && !m_up && m_val == 0)     nup = 1'b1;
`endif

        // debounced level flips once the synchronised samples disagree DB_CYCLES times running
        for (int b = 0; b < 3; b++) begin
            for (int j = DB_CYCLES + 1; j > 0; j--) hist[b][j] = hist[b][j-1];
            hist[b][0] = raw[b];
            flip = 1'b1;
            for (int j = 2; j <= DB_CYCLES + 1; j++) if (hist[b][j] == m_deb[b]) flip = 1'b0;
            m_press[b] = flip && !m_deb[b];
            if (flip) m_deb[b] = !m_deb[b];
        end

        m_state = nst;
        m_tick  = ntick;
        m_up    = nup;
        m_clr   = (nst == 3);
        m_val   = nval;
    endtask

    initial begin
        m_reset();
        forever begin
            @(posedge clk or posedge reset);
            if (reset) m_reset();
            else       m_step();
        end
    end

    always @(negedge clk) begin
        if (check_en) begin
            chk("cyc_tick",  32'(cnt_tick),  32'(m_tick));
            chk("cyc_up",    32'(cnt_up),    32'(m_up));
            chk("cyc_clr",   32'(cnt_clr),   32'(m_clr));
            chk("cyc_state", 32'(state),     32'(m_state));
            chk("cyc_led",   32'(run_led),   32'(m_state == 1));
            chk("cyc_value", 32'(cnt_value), 32'(m_val));
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: actual timeout, required completion");
        $fatal(1, "watchdog expired");
    end

    // ---------------- stimulus ----------------
    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_val(input int v, input int budget, input string name);
        int k;
        k = 0;
        while (32'(cnt_value) !== v && k < budget) begin
            cyc(1);
            k++;
        end
        chk(name, 32'(cnt_value), v);
    endtask

    task automatic press(input int b, input int hold);
        if (b == 0) btn_run = 1'b1; else if (b == 1) btn_dir = 1'b1; else btn_clr = 1'b1;
        cyc(hold);
        if (b == 0) btn_run = 1'b0; else if (b == 1) btn_dir = 1'b0; else btn_clr = 1'b0;
    endtask

    int ticks;

    initial begin
        #1 reset = 1'b1;
        cyc(2);
        reset    = 1'b0;
        check_en = 1'b1;
        chk("rst_state", 32'(state),    0);
        chk("rst_up",    32'(cnt_up),   1);
        chk("rst_tick",  32'(cnt_tick), 0);
        chk("rst_clr",   32'(cnt_clr),  0);
        chk("rst_led",   32'(run_led),  0);

        // 1: run press, first tick TICK_DIV cycles after RUN entry, counting up
        btn_run = 1'b1;
        cyc(5);  chk("p1_still_idle", 32'(state), 0);
        cyc(1);  chk("p1_run", 32'(state), 1); chk("p1_led", 32'(run_led), 1);
        cyc(3);  chk("p1_no_early_tick", 32'(cnt_tick), 0);
        cyc(1);  chk("p1_first_tick", 32'(cnt_tick), 1);
        btn_run = 1'b0;
        cyc(9);  chk("p1_value3", 32'(cnt_value), 3); chk("p1_up", 32'(cnt_up), 1);

        // 2: a two-cycle glitch is filtered, a clean press reverses direction
        press(1, 2);
        cyc(8);  chk("p2_glitch_ignored", 32'(cnt_up), 1);
        press(1, 6);
        chk("p2_dir_down", 32'(cnt_up), 0);
        chk("p2_value7", 32'(cnt_value), 7);
        cyc(4);  chk("p2_count_down", 32'(cnt_value), 6);

        // 3: pause with prescaler at 2, no ticks while paused, resume completes the period
        press(0, 4);
        cyc(2);  chk("p3_paused", 32'(state), 2);
        ticks = 0;
        repeat (20) begin
            cyc(1);
            if (cnt_tick) ticks++;
        end
        chk("p3_no_tick_paused", ticks, 0);
        chk("p3_value_held", 32'(cnt_value), 5);
        press(0, 4);
        cyc(2);  chk("p3_resumed", 32'(state), 1);
        cyc(1);  chk("p3_no_tick_yet", 32'(cnt_tick), 0);
        cyc(1);  chk("p3_resume_tick", 32'(cnt_tick), 1);

        // 4: clear and run pressed together: clear wins, one CLEAR cycle, then quiet IDLE
        btn_run = 1'b1;
        btn_clr = 1'b1;
        cyc(4);
        btn_run = 1'b0;
        btn_clr = 1'b0;
        cyc(2);  chk("p4_clear", 32'(state), 3); chk("p4_clr_pulse", 32'(cnt_clr), 1);
        cyc(1);  chk("p4_idle", 32'(state), 0); chk("p4_clr_off", 32'(cnt_clr), 0);
                 chk("p4_value0", 32'(cnt_value), 0);
        ticks = 0;
        repeat (30) begin
            cyc(1);
            if (cnt_tick) ticks++;
        end
        chk("p4_no_tick_after_clear", ticks, 0);
        chk("p4_still_idle", 32'(state), 0);

        // 5: count up through the top of the range
        press(1, 4);
        cyc(2);  chk("p5_dir_up", 32'(cnt_up), 1);
        press(0, 4);
        cyc(2);  chk("p5_run", 32'(state), 1);
        wait_val(14, 100, "p5_reach14");
        wait_val(15, 8, "p5_v15");
`ifdef UPDOWN_BOUNCE_MODE_EN
        wait_val(14, 8, "p5_bounce14");
        chk("p5_forced_down", 32'(cnt_up), 0);
        wait_val(13, 8, "p5_bounce13");
`else
        wait_val(0, 8, "p5_wrap0");
        chk("p5_still_up", 32'(cnt_up), 1);
        wait_val(1, 8, "p5_wrap1");
`endif

        // 6: asynchronous reset between edges, then a fresh start
        cyc(1);
        #2 reset = 1'b1;
        #1;
        chk("p6_async_state", 32'(state),    0);
        chk("p6_async_up",    32'(cnt_up),   1);
        chk("p6_async_tick",  32'(cnt_tick), 0);
        chk("p6_async_clr",   32'(cnt_clr),  0);
        chk("p6_async_led",   32'(run_led),  0);
        cyc(1);
        reset = 1'b0;
        press(0, 4);
        cyc(2);  chk("p6_run", 32'(state), 1);
        cyc(3);  chk("p6_no_early_tick", 32'(cnt_tick), 0);
        cyc(1);  chk("p6_restart_tick", 32'(cnt_tick), 1);

        // 7: randomized button activity with occasional mid-cycle resets
        for (int i = 0; i < 3000; i++) begin
            cyc(1);
            if ($urandom_range(0, 11) == 0) btn_run = ~btn_run;
            if ($urandom_range(0, 7)  == 0) btn_dir = ~btn_dir;
            if ($urandom_range(0, 40) == 0) btn_clr = ~btn_clr;
            if ($urandom_range(0, 599) == 0) begin
                #2 reset = 1'b1;
                @(negedge clk);
                reset = 1'b0;
            end
        end
        btn_run = 1'b0;
        btn_dir = 1'b0;
        btn_clr = 1'b0;
        cyc(8);
        check_en = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
